// File: rtl/btn_press_classifier_pkg.sv
// btn_press_classifier_pkg: state encodings and timing defaults shared by the button classifier.
package btn_press_classifier_pkg;

    localparam logic [1:0] ST_WAIT_LOW = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_LONG     = 2'd3;

    localparam int LONG_CYCLES_DEF   = 50_000_000;
    localparam int REPEAT_CYCLES_DEF = 10_000_000;
    localparam int CNT_W_DEF         = 27;

    function automatic logic is_pressed(input logic [1:0] st);
        return (st == ST_HELD) || (st == ST_LONG);
    endfunction

endpackage

// File: rtl/btn_press_classifier.sv
// btn_press_classifier: turns a debounced button level into press/short/long/auto-repeat pulses.
// The auto-repeat output is named rpt because repeat is a reserved word.
module btn_press_classifier
    import btn_press_classifier_pkg::*;
#(
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press,
    output logic short_press,
    output logic long_press,
    output logic rpt,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             press_n, short_n, long_n, rpt_n;

    // Release is tested before the terminal count so a coinciding release wins.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        press_n = 1'b0;
        short_n = 1'b0;
        long_n  = 1'b0;
        rpt_n   = 1'b0;
        case (state)
            ST_WAIT_LOW: state_n = btn_in ? ST_WAIT_LOW : ST_IDLE;
            ST_IDLE: begin
                if (btn_in) begin
                    state_n = ST_HELD;
                    cnt_n   = '0;
                    press_n = 1'b1;
                end
            end
            ST_HELD: begin
                if (!btn_in) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    short_n = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_n = ST_LONG;
                    cnt_n   = '0;
                    long_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                if (!btn_in) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (cnt == REP_LAST) begin
                    cnt_n = '0;
                    rpt_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_WAIT_LOW;
            cnt         <= '0;
            press       <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            rpt         <= 1'b0;
            held        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            press       <= press_n;
            short_press <= short_n;
            long_press  <= long_n;
            rpt         <= rpt_n;
            held        <= is_pressed(state_n);
        end
    end

endmodule

// File: tb/tb_btn_press_classifier.sv
// tb_btn_press_classifier: directed vector table plus randomized run against an elapsed-time model.
module tb_btn_press_classifier;

    localparam int L = 8;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst, btn_in;
    logic press, short_press, long_press, rpt, held;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    btn_press_classifier #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .press(press), .short_press(short_press),
        .long_press(long_press), .rpt(rpt), .held(held)
    );

    // Expected outputs packed as {press, short_press, long_press, rpt, held}.
    typedef struct {
        logic       r;
        logic       b;
        logic [4:0] exp;
    } vec_t;

    vec_t vq[$];

    // Model: tracks whether the button has been seen low and edges elapsed since the press edge.
    bit         m_armed = 0;
    bit         m_pressed = 0;
    int         m_k = 0;
    logic [4:0] m_exp = '0;

    function automatic logic [4:0] outs();
        return {press, short_press, long_press, rpt, held};
    endfunction

    task automatic add(input logic r, b, p, s, l, rp, h);
        vec_t v;
        v.r = r;
        v.b = b;
        v.exp = {p, s, l, rp, h};
        vq.push_back(v);
    endtask

    task automatic add_n(input int n, input logic r, b, h);
        for (int i = 0; i < n; i++) add(r, b, 1'b0, 1'b0, 1'b0, 1'b0, h);
    endtask

    task automatic model_edge(input logic r, b);
        logic p, s, l, rp;
        p = 0; s = 0; l = 0; rp = 0;
        if (r) begin
            m_armed = 0;
            m_pressed = 0;
        end else if (!m_armed) begin
            if (!b) m_armed = 1;
        end else if (!m_pressed) begin
            if (b) begin
                m_pressed = 1;
                m_k = 0;
                p = 1;
            end
        end else begin
            m_k++;
            if (!b) begin
                m_pressed = 0;
                s = (m_k <= L);
            end else if (m_k == L) begin
                l = 1;
            end else if (m_k > L && (m_k - L) % R == 0) begin
                rp = 1;
            end
        end
        m_exp = {p, s, l, rp, logic'(m_pressed)};
    endtask

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got {press,short,long,rpt,held}=%b expected %b", name, got, exp);
        end
    endtask

    task automatic cycle(input logic r, b);
        rst = r;
        btn_in = b;
        @(posedge clk);
        model_edge(r, b);
        #1;
    endtask

    initial begin
        bit   pending;
        logic lvl, r;
        int   len, cyc;
        rst = 1'b1;
        btn_in = 1'b0;
        // Button held through reset: nothing until seen low once.
        add_n(2, 1, 1, 0);
        add_n(20, 0, 1, 0);
        add_n(1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0);
        // Five-cycle short press.
        add(0, 1, 1, 0, 0, 0, 1);
        add_n(4, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0);
        add_n(1, 0, 0, 0);
        // Twenty-cycle hold: long at row 9, repeats at rows 13 and 17, silent release.
        add(0, 1, 1, 0, 0, 0, 1);
        add_n(7, 0, 1, 1);
        add(0, 1, 0, 0, 1, 0, 1);
        add_n(3, 0, 1, 1);
        add(0, 1, 0, 0, 0, 1, 1);
        add_n(3, 0, 1, 1);
        add(0, 1, 0, 0, 0, 1, 1);
        add_n(3, 0, 1, 1);
        add_n(2, 0, 0, 0);
        // Release on the terminal edge: short only.
        add(0, 1, 1, 0, 0, 0, 1);
        add_n(7, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0);
        // Reset mid-LONG with button still down.
        add(0, 1, 1, 0, 0, 0, 1);
        add_n(7, 0, 1, 1);
        add(0, 1, 0, 0, 1, 0, 1);
        add_n(2, 0, 1, 1);
        add_n(1, 1, 1, 0);
        add_n(10, 0, 1, 0);
        add_n(1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0);

        foreach (vq[i]) begin
            cycle(vq[i].r, vq[i].b);
            check($sformatf("vec[%0d]", i), outs(), vq[i].exp);
        end

        cycle(1, 0);
        check("rand_reset", outs(), m_exp);
        pending = 0;
        cyc = 0;
        while (cyc < 10000) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 25);
            for (int j = 0; j < len; j++) begin
                r = ($urandom_range(0, 499) == 0);
                cycle(r, lvl);
                cyc++;
                check($sformatf("model@%0d", cyc), outs(), m_exp);
                n_chk++;
                if ($countones(outs() >> 1) > 1) begin
                    n_fail++;
                    $display("FAIL onehot@%0d got pulses=%b required at most one high", cyc, outs() >> 1);
                end
                if (r) begin
                    pending = 0;
                end else begin
                    if (press) begin
                        n_chk++;
                        if (pending) begin
                            n_fail++;
                            $display("FAIL pairing@%0d got press while unresolved required resolution first", cyc);
                        end
                        pending = 1;
                    end
                    if (short_press || long_press) begin
                        n_chk++;
                        if (!pending) begin
                            n_fail++;
                            $display("FAIL pairing@%0d got short/long=%b%b without press required none", cyc, short_press, long_press);
                        end
                        pending = 0;
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
